// File: rtl/shift_add_mul8.sv
// shift_add_mul8: sequential 8x8 unsigned multiplier, one add/shift step per multiplier bit
// through a single shared bit8_FA ripple-carry adder.
module bit8_FA (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[8];
endmodule

module shift_add_mul8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d, a_q, a_d, q_q, q_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;
  logic [7:0]  sum;
  logic        cout;
  bit8_FA u_fa (.a(a_q), .b(m_q), .cin(1'b0), .sum(sum), .cout(cout));
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: if (start) begin
        m_d     = a;
        q_d     = b;
        a_d     = 8'd0;
        c_d     = 1'b0;
        cnt_d   = 4'd0;
        state_d = ADD;
      end
      ADD: begin
        c_d     = q_q[0] & cout;
        a_d     = q_q[0] ? sum : a_q;
        state_d = SHIFT;
      end
      SHIFT: begin
        {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[7:1]};
        cnt_d   = cnt_q + 4'd1;
        // Last iteration: capture the post-shift {A,Q} as the product.
        p_d     = (cnt_q == 4'd7) ? {c_q, a_q, q_q[7:1]} : p_q;
        state_d = (cnt_q == 4'd7) ? DONE : ADD;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 8'd0;
      a_q     <= 8'd0;
      q_q     <= 8'd0;
      c_q     <= 1'b0;
      cnt_q   <= 4'd0;
      p_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end
  assign busy = (state_q == ADD) || (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign p    = p_q;
endmodule

// File: tb/tb_shift_add_mul8.sv
// tb_shift_add_mul8: table vectors, handshake corner sequences and a random sweep
// against a plain a*b reference with latency/busy/p-stability checks.
module tb_shift_add_mul8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = 8'd0, b = 8'd0;
  logic        busy, done;
  logic [15:0] p;
  int          vecs = 0, errs = 0;

  shift_add_mul8 dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                      .busy(busy), .done(done), .p(p));

  always #5 clk = ~clk;

  typedef struct {logic [7:0] a; logic [7:0] b; logic [15:0] p;} vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Starts one operation from IDLE and follows it to its done pulse.
  task automatic op(input logic [7:0] x, input logic [7:0] y, output logic [15:0] pr,
                    output int lat, output int bcnt, output int pchg);
    logic [15:0] p0;
    @(negedge clk);
    p0 = p;
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; bcnt = 0; pchg = 0; pr = 16'hxxxx;
    for (int j = 0; j < 40; j++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = j; pr = p;
        break;
      end
      if (p !== p0) pchg++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp);
    logic [15:0] pr;
    int lat, bcnt, pchg;
    op(x, y, pr, lat, bcnt, pchg);
    chk({name, " p"}, pr, exp);
    chk({name, " latency"}, lat, 16);
    chk({name, " busy cycles"}, bcnt, 16);
    chk({name, " p stable"}, pchg, 0);
  endtask

  initial begin
    logic [15:0] pr;
    int lat, bcnt, pchg, d1, d2, lowc, nd;
    logic [7:0] x, y;
    logic [15:0] exp;
    tbl[0] = '{8'h0D, 8'h0B, 16'h008F};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{8'h80, 8'h02, 16'h0100};
    tbl[3] = '{8'h00, 8'hA5, 16'h0000};
    tbl[4] = '{8'h01, 8'h01, 16'h0001};
    tbl[5] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[6] = '{8'h01, 8'hFF, 16'h00FF};

    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset p", p, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) check_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p);

    // start held high: one product every 18 cycles, busy low only in DONE and IDLE.
    @(negedge clk);
    a = 8'h03; b = 8'h05; start = 1'b1;
    d1 = -1; d2 = -1; lowc = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done && d1 >= 0 && d2 < 0) begin
        d2 = t;
        chk("b2b p second", p, 16'h000F);
        start = 1'b0;
        break;
      end
      if (done && d1 < 0) begin
        d1 = t;
        chk("b2b p first", p, 16'h000F);
      end
      if (d1 >= 0 && !busy) lowc++;
    end
    chk("b2b period", d2 - d1, 18);
    chk("b2b busy low", lowc, 2);
    @(negedge clk);

    // Operand change and extra start mid-operation are ignored.
    @(negedge clk);
    a = 8'h0D; b = 8'h0B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (j == 6) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      if (j == 7) start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = j; chk("ignore p", p, 16'h008F); end
      end
      @(negedge clk);
    end
    chk("ignore latency", lat, 16);
    chk("ignore single done", nd, 1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst p", p, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int j = 0; j < 25; j++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("no done after rst", nd, 0);
    check_op("post rst", 8'h10, 8'h10, 16'h0100);

    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      exp = 16'(32'(x) * 32'(y));
      op(x, y, pr, lat, bcnt, pchg);
      vecs++;
      if (pr !== exp || lat != 16 || bcnt != 16 || pchg != 0) begin
        errs++;
        $display("FAIL rand %0h*%0h: got p=%0h lat=%0d busy=%0d pchg=%0d, expected p=%0h lat=16 busy=16 pchg=0",
                 x, y, pr, lat, bcnt, pchg, exp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
